// File: rtl/serial_tx4b.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on load/ready and
// shifts it out one bit per clock with a valid strobe and a done pulse on the last bit.
module serial_tx4b #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sval,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sout_n, sval_n, done_n;
  logic             accept;

  // ready comes from registered state only, so load never reaches it combinationally
  assign ready  = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
  assign accept = load && ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      sout  <= 1'b0;
      sval  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      sout  <= sout_n;
      sval  <= sval_n;
      done  <= done_n;
    end
  end

  // sh holds only the bits not yet presented; the bit on sout was already peeled off
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    sout_n  = 1'b0;
    sval_n  = 1'b0;
    done_n  = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sval_n  = 1'b1;
      if (MSB_FIRST != 0) begin
        sout_n = din[WIDTH-1];
        sh_n   = din << 1;
      end else begin
        sout_n = din[0];
        sh_n   = din >> 1;
      end
    end else if ((state == SHIFT) && (cnt != LAST)) begin
      cnt_n  = cnt + 1'b1;
      sval_n = 1'b1;
      done_n = (cnt_n == LAST);
      if (MSB_FIRST != 0) begin
        sout_n = sh[WIDTH-1];
        sh_n   = sh << 1;
      end else begin
        sout_n = sh[0];
        sh_n   = sh >> 1;
      end
    end else if (state == SHIFT) begin
      state_n = IDLE;
      cnt_n   = '0;
      sh_n    = '0;
    end
  end

endmodule

// File: tb/tb_serial_tx4b.sv
// Directed testbench for serial_tx4b: one MSB-first and one LSB-first instance,
// each scenario task checks the serial stream cycle by cycle against hand-computed values.
module tb_serial_tx4b;

  logic       clk;
  logic       clr;
  logic [3:0] din;
  logic       load_m, load_l;
  logic       ready_m, sout_m, sval_m, done_m;
  logic       ready_l, sout_l, sval_l, done_l;
  logic [3:0] sipo;
  int         checks;
  int         errors;

  serial_tx4b #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .clr(clr), .din(din), .load(load_m),
    .ready(ready_m), .sout(sout_m), .sval(sval_m), .done(done_m)
  );

  serial_tx4b #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .clr(clr), .din(din), .load(load_l),
    .ready(ready_l), .sout(sout_l), .sval(sval_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial-in receiver used by the loopback scenario
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) sipo <= 4'b0000;
    else if (sval_m) sipo <= {sipo[2:0], sout_m};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b0;
    #3;
    checks++;
    if ({ready_m, sout_m, sval_m, done_m} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_m: ready/sout/sval/done got %b expected 1000",
               {ready_m, sout_m, sval_m, done_m});
    end
    checks++;
    if ({ready_l, sout_l, sval_l, done_l} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_l: ready/sout/sval/done got %b expected 1000",
               {ready_l, sout_l, sval_l, done_l});
    end
    tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic test_single;
    logic [3:0] w;
    w      = 4'b1011;
    din    = w;
    load_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      load_m = 1'b0;
      checks++;
      if ({sout_m, sval_m, done_m, ready_m} !== {w[3-k], 1'b1, k == 3, k == 3}) begin
        errors++;
        $display("[TB] FAIL single bit%0d: sout/sval/done/ready got %b expected %b", k,
                 {sout_m, sval_m, done_m, ready_m}, {w[3-k], 1'b1, k == 3, k == 3});
      end
    end
    tick();
    checks++;
    if ({sout_m, sval_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single idle: sout/sval/done/ready got %b expected 0001",
               {sout_m, sval_m, done_m, ready_m});
    end
  endtask

  task automatic test_lsb_first;
    logic [3:0] w;
    w      = 4'b1011;
    din    = w;
    load_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      load_l = 1'b0;
      checks++;
      if ({sout_l, sval_l, done_l} !== {w[k], 1'b1, k == 3}) begin
        errors++;
        $display("[TB] FAIL lsb bit%0d: sout/sval/done got %b expected %b", k,
                 {sout_l, sval_l, done_l}, {w[k], 1'b1, k == 3});
      end
    end
    tick();
    checks++;
    if ({sval_l, ready_l} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL lsb idle: sval/ready got %b expected 01", {sval_l, ready_l});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    s      = 8'b1011_0110;
    din    = 4'b1011;
    load_m = 1'b1;
    tick();
    din = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if (k == 4) load_m = 1'b0;
      checks++;
      if ({sout_m, sval_m, done_m} !== {s[7-k], 1'b1, (k == 3) || (k == 7)}) begin
        errors++;
        $display("[TB] FAIL b2b bit%0d: sout/sval/done got %b expected %b", k,
                 {sout_m, sval_m, done_m}, {s[7-k], 1'b1, (k == 3) || (k == 7)});
      end
    end
    tick();
    checks++;
    if ({sval_m, done_m, ready_m} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL b2b idle: sval/done/ready got %b expected 001",
               {sval_m, done_m, ready_m});
    end
  endtask

  task automatic test_load_busy;
    logic [3:0] w;
    int         ndone;
    w      = 4'b1011;
    ndone  = 0;
    din    = w;
    load_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      load_m = 1'b0;
      if (k == 1) begin
        din    = 4'b1111;
        load_m = 1'b1;
      end
      if (done_m) ndone++;
      checks++;
      if ({sout_m, sval_m} !== {w[3-k], 1'b1}) begin
        errors++;
        $display("[TB] FAIL busy bit%0d: sout/sval got %b expected %b", k,
                 {sout_m, sval_m}, {w[3-k], 1'b1});
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (done_m) ndone++;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("[TB] FAIL busy done_count: got %0d expected 1", ndone);
    end
    checks++;
    if ({sval_m, ready_m} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL busy idle: sval/ready got %b expected 01", {sval_m, ready_m});
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] w;
    din    = 4'b1011;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    tick();
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if ({sout_m, sval_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midreset: sout/sval/done/ready got %b expected 0001",
               {sout_m, sval_m, done_m, ready_m});
    end
    tick();
    clr    = 1'b1;
    w      = 4'b0110;
    din    = w;
    load_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      load_m = 1'b0;
      checks++;
      if ({sout_m, sval_m, done_m} !== {w[3-k], 1'b1, k == 3}) begin
        errors++;
        $display("[TB] FAIL after_reset bit%0d: sout/sval/done got %b expected %b", k,
                 {sout_m, sval_m, done_m}, {w[3-k], 1'b1, k == 3});
      end
    end
    tick();
  endtask

  task automatic test_loopback;
    din    = 4'b1001;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({done_m, sipo[2:0], sout_m} !== 5'b1_1001) begin
      errors++;
      $display("[TB] FAIL loopback_done: done/stages/sout got %b expected 11001",
               {done_m, sipo[2:0], sout_m});
    end
    tick();
    checks++;
    if (sipo !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL loopback_word: got %b expected 1001", sipo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr    = 1'b1;
    din    = 4'b0000;
    load_m = 1'b0;
    load_l = 1'b0;
    #2;
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_load_busy();
    test_reset_mid();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
